result_dec_ascii_tx: RTL and testbench
======================================

// Module: result_dec_ascii_tx
// PURPOSE
//  Downstream stage of the puzzle solvers. Captures the binary sum a solver presents on result/output_valid.
//  Converts it to decimal by serial double-dabble (shift-add-3).
//  Streams the decimal digits as ASCII bytes, MSD first, followed by an optional '\n'.
//  Output uses a valid/ready byte handshake, so the answer can be printed or checked byte-wise.
// PARAMETERS
//  WIDTH        64  bit width of the binary result
//  MAX_DIGITS   20  BCD digit count; must be >= ceil(WIDTH*log10(2)), elaboration error otherwise
//  EMIT_NEWLINE 1   1: append 8'h0A after the last digit; 0: no terminator
// PORTS
//  clk          in   1          clock
//  rst_n        in   1          reset, synchronous, active-low
//  result_in    in   WIDTH      binary value from solver
//  result_valid in   1          solver output_valid; level, may stay high indefinitely
//  char_out     out  8          ASCII byte
//  char_valid   out  1          char_out holds a byte
//  char_ready   in   1          consumer accepts byte when char_valid&&char_ready
//  busy         out  1          high in every state except IDLE
//  done         out  1          1-cycle pulse on acceptance of the final byte
//  overrun      out  1          sticky: a trigger arrived while busy (cleared only by reset)
// BEHAVIOUR
//  Reset: all regs are synchronous on clk while rst_n==0.
//   Resulting values: state=IDLE, char_out=0, char_valid=0, busy=0, done=0, overrun=0, valid_q=0.
//  Trigger = result_valid & ~valid_q (rising edge); valid_q <= result_valid every cycle.
//   A level held high across reset therefore triggers once after reset.
//  IDLE: on trigger at cycle t, latch bin<=result_in, bcd<=0, cnt<=0 -> CONVERT.
//  CONVERT: runs for cycles t+1..t+WIDTH.
//   Each cycle: every nibble >=5 gets +3, then {bcd,bin} shift left by 1.
//   After WIDTH shifts -> SKIP with idx=MAX_DIGITS-1.
//  SKIP: each cycle, if idx!=0 && nibble[idx]==0 then idx-- else -> EMIT.
//   Lasts L+1 cycles, L = leading-zero digits (0..MAX_DIGITS-1). Value 0 yields the single digit '0'.
//  EMIT: char_valid=1, char_out=8'h30+nibble[idx]. First char_valid is at cycle t+WIDTH+L+2.
//   On handshake: if idx!=0, idx-- (next digit valid next cycle, no bubble)
//   else -> NEWLINE (EMIT_NEWLINE=1) or IDLE with done pulse.
//  NEWLINE: char_out=8'h0A, char_valid=1; on handshake -> IDLE, done=1 that cycle.
//  Backpressure: while char_valid && !char_ready, char_out and state are held stable.
//   char_valid never drops without a handshake.
//  Trigger while busy: ignored (no recapture, current stream unaffected); overrun<=1.
//  Trigger in the cycle that returns to IDLE: ignored (state was not IDLE when sampled).
//  Reset mid-operation: next cycle is IDLE with char_valid=0; partial stream is abandoned, no done.
//  Widths: bcd reg 4*MAX_DIGITS bits, cnt $clog2(WIDTH+1), idx $clog2(MAX_DIGITS); add-3 is 4-bit, no carry out.
// STRUCTURE
//  Package aoc_fmt_pkg holds:
//   - state enum {IDLE, CONVERT, SKIP, EMIT, NEWLINE}
//   - CHAR_ZERO=8'h30, CHAR_NL=8'h0A
//  Sub-module bin2bcd_step (combinational, param MAX_DIGITS):
//   - inputs bcd and bin MSB; output corrected+shifted bcd
//   - one instance, used in CONVERT
//  Top holds FSM, counters, edge detect, handshake regs.
// TESTING
//  1. result_in=0, edge at t -> '0'(8'h30) first valid at t+85, then 8'h0A, done on NL handshake.
//  2. result_in=142, ready=1 -> bytes 31,34,32,0A on consecutive cycles, then done.
//  3. result_in=2^64-1 -> 18446744073709551615 (20 digits, L=0), first byte at t+66.
//  4. result_in=54321, ready toggling 1/0 each cycle -> 35,34,33,32,31,0A; char_out stable while stalled.
//  5. result_valid held high 300 cycles -> exactly one stream. Low-high pulse mid-CONVERT -> overrun=1, stream unchanged.
//  6. rst_n low for 1 cycle during EMIT -> next cycle char_valid=0, busy=0. New edge with 7 -> 37,0A.

Source files
------------

// File: rtl/aoc_fmt_pkg.sv
// Shared definitions for the result formatter.
// Contents:
//   IDLE..NEWLINE  FSM state encodings
//   CHAR_ZERO      ASCII '0'
//   CHAR_NL        ASCII line feed
//   add3           double-dabble digit correction (4-bit, no carry out)
package aoc_fmt_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CONVERT = 3'd1;
  localparam logic [2:0] SKIP    = 3'd2;
  localparam logic [2:0] EMIT    = 3'd3;
  localparam logic [2:0] NEWLINE = 3'd4;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_NL   = 8'h0A;

  // A digit of 5 or more becomes >= 10 after the next doubling, so it is
  // pre-corrected by 3. The result always fits in 4 bits.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add-3 correction on every BCD digit, then a
// left shift of the BCD register with the binary MSB shifted in.
// Ports:
//   bcd      in   4*MAX_DIGITS  current BCD accumulator
//   bin_msb  in   1             MSB of the binary shift register
//   bcd_next out  4*MAX_DIGITS  corrected and shifted accumulator
module bin2bcd_step
  import aoc_fmt_pkg::*;
#(
  parameter int MAX_DIGITS = 20
) (
  input  logic [4*MAX_DIGITS-1:0] bcd,
  input  logic                    bin_msb,
  output logic [4*MAX_DIGITS-1:0] bcd_next
);

  logic [4*MAX_DIGITS-1:0] adj;

  always_comb begin
    adj = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      adj[4*i +: 4] = add3(bcd[4*i +: 4]);
    end
  end

  assign bcd_next = {adj[4*MAX_DIGITS-2:0], bin_msb};

endmodule

// File: rtl/result_dec_ascii_tx.sv
// Captures a binary result on the rising edge of result_valid, converts it
// to decimal by serial double-dabble and streams the digits as ASCII bytes
// (most significant first, leading zeros suppressed), optionally followed
// by a line feed, over a valid/ready byte interface.
// Ports:
//   clk          in   clock
//   rst_n        in   synchronous active-low reset
//   result_in    in   binary value from solver (WIDTH bits)
//   result_valid in   level valid from solver; rising edge starts a stream
//   char_out     out  ASCII byte
//   char_valid   out  char_out holds a byte
//   char_ready   in   consumer accepts when char_valid && char_ready
//   busy         out  high whenever the FSM is not IDLE
//   done         out  high in the cycle the final byte is accepted
//   overrun      out  sticky: a trigger arrived while busy
module result_dec_ascii_tx
  import aoc_fmt_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int MAX_DIGITS   = 20,
  parameter bit EMIT_NEWLINE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] result_in,
  input  logic             result_valid,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int BCD_W = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(MAX_DIGITS);
  // ceil(WIDTH * log10(2)) in integer arithmetic
  localparam int DIGITS_NEEDED = (WIDTH * 30103 + 99999) / 100000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(MAX_DIGITS - 1);

  if (MAX_DIGITS < DIGITS_NEEDED) begin : g_bad_digits
    $error("result_dec_ascii_tx: MAX_DIGITS too small for WIDTH");
  end

  logic [2:0]       state;
  logic             valid_q;
  logic [WIDTH-1:0] bin;
  logic [BCD_W-1:0] bcd;
  logic [BCD_W-1:0] bcd_next;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_dn;
  logic [3:0]       cur_nib;
  logic [3:0]       next_nib;
  logic             trigger;

  assign trigger  = result_valid & ~valid_q;
  assign busy     = (state != IDLE);
  assign idx_dn   = idx - 1'b1;
  assign cur_nib  = 4'(bcd >> {idx, 2'b00});
  assign next_nib = 4'(bcd >> {idx_dn, 2'b00});

  // done is tied to the handshake itself so it coincides with acceptance
  // of the last byte rather than trailing it by a cycle.
  assign done = char_valid && char_ready &&
                ((state == NEWLINE) ||
                 ((state == EMIT) && (idx == '0) && !EMIT_NEWLINE));

  bin2bcd_step #(
    .MAX_DIGITS (MAX_DIGITS)
  ) u_step (
    .bcd      (bcd),
    .bin_msb  (bin[WIDTH-1]),
    .bcd_next (bcd_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      char_out   <= '0;
      char_valid <= 1'b0;
      overrun    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= result_valid;
      if (trigger && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            bin   <= result_in;
            bcd   <= '0;
            cnt   <= '0;
            state <= CONVERT;
          end
        end
        // conversion: one shift-add-3 per cycle, WIDTH cycles
        CONVERT: begin
          bcd <= bcd_next;
          bin <= {bin[WIDTH-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            idx   <= IDX_TOP;
            state <= SKIP;
          end
        end
        // leading-zero suppression; digit 0 is always printed
        SKIP: begin
          if ((idx != '0) && (cur_nib == 4'd0)) begin
            idx <= idx_dn;
          end else begin
            char_out   <= CHAR_ZERO + {4'h0, cur_nib};
            char_valid <= 1'b1;
            state      <= EMIT;
          end
        end
        // digit output; next digit is loaded on the handshake so there is
        // no bubble between consecutive bytes
        EMIT: begin
          if (char_ready) begin
            if (idx != '0) begin
              idx      <= idx_dn;
              char_out <= CHAR_ZERO + {4'h0, next_nib};
            end else if (EMIT_NEWLINE) begin
              char_out <= CHAR_NL;
              state    <= NEWLINE;
            end else begin
              char_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        NEWLINE: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          char_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_dec_ascii_tx.sv
module tb_result_dec_ascii_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] result_in;
  logic        result_valid;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;
  logic        busy;
  logic        done;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int done_count = 0;
  logic [7:0] exp_q[$];
  bit toggle_on = 1'b0;
  bit hold_valid = 1'b0;
  logic [7:0] held_char;

  typedef struct {
    logic [63:0] value;
    int          exp_lat;
    int          exp_len;
    bit          toggle;
  } vec_t;

  vec_t vecs[6];

  result_dec_ascii_tx #(
    .WIDTH        (64),
    .MAX_DIGITS   (20),
    .EMIT_NEWLINE (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .result_in    (result_in),
    .result_valid (result_valid),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout", name);
  endtask

  // Reference model: decimal digits by repeated division, then line feed.
  task automatic push_model(input logic [63:0] v);
    logic [7:0]  d[$];
    logic [63:0] x;
    x = v;
    if (x == 64'd0) d.push_front(8'h30);
    while (x != 64'd0) begin
      d.push_front(8'h30 + 8'(x % 64'd10));
      x = x / 64'd10;
    end
    foreach (d[i]) exp_q.push_back(d[i]);
    exp_q.push_back(8'h0A);
  endtask

  always @(posedge clk) begin
    #1;
    if (toggle_on) char_ready = ~char_ready;
  end

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_valid) begin
        check("valid_held", {63'b0, char_valid}, 64'd1);
        check("stall_stable", {56'b0, char_out}, {56'b0, held_char});
      end
      if (char_valid && char_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_byte: got=%0h want=none", char_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte", {56'b0, char_out}, {56'b0, e});
          check("done_flag", {63'b0, done}, {63'b0, (exp_q.size() == 0)});
        end
        if (done) done_count++;
      end else if (done) begin
        total++;
        bad++;
        $display("FAIL done_no_handshake: got=1 want=0");
      end
      hold_valid = char_valid && !char_ready;
      held_char  = char_out;
    end else begin
      hold_valid = 1'b0;
    end
  end

  task automatic run_vec(input vec_t v);
    int n;
    int m;
    int hs0;
    int dc0;
    bit got;
    char_ready = 1'b1;
    toggle_on  = v.toggle;
    hs0 = hs_count;
    dc0 = done_count;
    @(posedge clk);
    #1;
    result_in    = v.value;
    result_valid = 1'b1;
    push_model(v.value);
    @(negedge clk);
    n = 0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (char_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (got) check("first_latency", 64'(n), 64'(v.exp_lat));
    else fail_now("first_valid");
    m = 0;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      m++;
    end
    if (!got) fail_now("done_wait");
    else if (!v.toggle) check("stream_cycles", 64'(m), 64'(v.exp_len - 1));
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    toggle_on    = 1'b0;
    char_ready   = 1'b1;
    check("byte_count", 64'(hs_count - hs0), 64'(v.exp_len));
    check("done_count", 64'(done_count - dc0), 64'd1);
    @(negedge clk);
    check("idle_busy", {63'b0, busy}, 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int dc0;

    vecs[0] = '{64'd0,                    85,  2, 1'b0};
    vecs[1] = '{64'd142,                  83,  4, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF,  66, 21, 1'b0};
    vecs[3] = '{64'd54321,                81,  6, 1'b1};
    vecs[4] = '{64'd1000000,              79,  8, 1'b0};
    vecs[5] = '{64'd10000000000000000000, 66, 21, 1'b0};

    rst_n        = 1'b0;
    result_in    = '0;
    result_valid = 1'b0;
    char_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_char_valid", {63'b0, char_valid}, 64'd0);
    check("rst_char_out", {56'b0, char_out}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_overrun", {63'b0, overrun}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Level held high: exactly one stream, no overrun.
    dc0 = done_count;
    @(posedge clk);
    #1;
    result_in    = 64'd99;
    result_valid = 1'b1;
    push_model(64'd99);
    repeat (300) @(posedge clk);
    #1;
    check("hold_streams", 64'(done_count - dc0), 64'd1);
    check("hold_overrun", {63'b0, overrun}, 64'd0);
    check("hold_queue", 64'(exp_q.size()), 64'd0);
    result_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Second edge during CONVERT: ignored, flags overrun.
    dc0 = done_count;
    #1;
    result_in    = 64'd4242;
    result_valid = 1'b1;
    push_model(64'd4242);
    repeat (10) @(posedge clk);
    #1;
    result_valid = 1'b0;
    result_in    = 64'd1;
    @(posedge clk);
    #1;
    result_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("overrun_done");
    @(posedge clk);
    #1;
    check("overrun_set", {63'b0, overrun}, 64'd1);
    check("overrun_queue", 64'(exp_q.size()), 64'd0);
    check("overrun_streams", 64'(done_count - dc0), 64'd1);
    result_valid = 1'b0;
    repeat (2) @(posedge clk);

    // Reset while stalled in EMIT.
    #1;
    char_ready   = 1'b0;
    result_in    = 64'd123;
    result_valid = 1'b1;
    push_model(64'd123);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (char_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("emit_wait");
    result_valid = 1'b0;
    check("stalled_busy", {63'b0, busy}, 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", {63'b0, char_valid}, 64'd0);
    check("mid_rst_busy", {63'b0, busy}, 64'd0);
    check("mid_rst_overrun", {63'b0, overrun}, 64'd0);
    check("mid_rst_done", {63'b0, done}, 64'd0);
    run_vec('{64'd7, 85, 2, 1'b0});

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
